dt_engine_param: RTL and testbench

Parametrised two-pass distance-transform engine, the successor to the fixed 128x128 chessboard DT core.
- Reads a 1-bpp binary image from packed STI ROM words.
- Writes per-pixel distance-to-background into RES RAM.
- Adds run-time metric select (chessboard / city-block), configurable geometry and distance width, start/busy handshake and distance saturation.
- Sits between the STI ROM and RES RAM in the DT subsystem top.

---
 rtl/dt_pkg.sv | 76 +++++++
 rtl/dt_nbr_min.sv | 46 ++++
 rtl/dt_engine_param.sv | 172 +++++++++++++++++
 tb/tb_dt_engine_param.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
`default_nettype none
//==============================================================================
// dt_pkg - shared state type, metric constants, neighbour tables and clamp. Rev 1.0
//==============================================================================
package dt_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FWD_CHK = 3'd1,
      FWD_RD  = 3'd2,
      FWD_WR  = 3'd3,
      BWD_CHK = 3'd4,
      BWD_RD  = 3'd5,
      BWD_WR  = 3'd6,
      DONE    = 3'd7
   } state_t;

   localparam logic       DT_CHESS = 1'b0;
   localparam logic       DT_CITY  = 1'b1;
   localparam int         NBR_N    = 5;
   localparam logic [2:0] SELF_IDX = 3'd4;

   // Offset of neighbour k from p; the backward lists end with p itself.
   function automatic int nbr_ofs(input logic bwd, input logic mode, input logic [2:0] k,
                                  input int img_w);
      int ofs;
      ofs = 0;
      case ({bwd, mode})
         2'b00: begin
            case (k)
               3'd0:    ofs = -img_w - 1;
               3'd1:    ofs = -img_w;
               3'd2:    ofs = -img_w + 1;
               default: ofs = -1;
            endcase
         end
         2'b01:   ofs = (k == 3'd0) ? -img_w : -1;
         2'b10: begin
            case (k)
               3'd0:    ofs = img_w + 1;
               3'd1:    ofs = img_w;
               3'd2:    ofs = img_w - 1;
               3'd3:    ofs = 1;
               default: ofs = 0;
            endcase
         end
         default: begin
            case (k)
               3'd0:    ofs = img_w;
               3'd1:    ofs = 1;
               default: ofs = 0;
            endcase
         end
      endcase
      return ofs;
   endfunction

   function automatic logic [2:0] nbr_last(input logic bwd, input logic mode);
      logic [2:0] last;
      case ({bwd, mode})
         2'b00:   last = 3'd3;
         2'b01:   last = 3'd1;
         2'b10:   last = 3'd4;
         default: last = 3'd2;
      endcase
      return last;
   endfunction

   function automatic int unsigned sat(input int unsigned v, input int dist_w);
      int unsigned max_v;
      max_v = (32'd1 << dist_w) - 32'd1;
      return (v > max_v) ? max_v : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dt_nbr_min.sv
`default_nettype none
//==============================================================================
// dt_nbr_min - neighbour register file with min / +1 / clamp / min-with-self. Rev 1.0
//==============================================================================
module dt_nbr_min
   import dt_pkg::*;
#(
   parameter int DIST_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              we,
   input  logic [2:0]        idx,
   input  logic [DIST_W-1:0] din,
   output logic [DIST_W-1:0] dout
);

   logic [DIST_W-1:0] nbr [NBR_N];
   logic [DIST_W-1:0] nbr_min;
   logic [DIST_W:0]   sum;
   logic [DIST_W-1:0] inc;

   // Unused slots sit at all-ones so they never win the minimum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NBR_N; i++) nbr[i] <= '1;
      end else if (clr) begin
         for (int i = 0; i < NBR_N; i++) nbr[i] <= '1;
      end else if (we && (idx <= SELF_IDX)) begin
         nbr[idx] <= din;
      end
   end

   always_comb begin
      nbr_min = nbr[0];
      for (int i = 1; i < NBR_N - 1; i++) begin
         if (nbr[i] < nbr_min) nbr_min = nbr[i];
      end
      sum  = {1'b0, nbr_min} + {{DIST_W{1'b0}}, 1'b1};
      inc  = DIST_W'(sat(32'(sum), DIST_W));
      dout = (nbr[SELF_IDX] < inc) ? nbr[SELF_IDX] : inc;
   end

endmodule
`default_nettype wire

// File: rtl/dt_engine_param.sv
`default_nettype none
//==============================================================================
// dt_engine_param - two-pass chessboard/city-block distance transform engine. Rev 1.0
//==============================================================================
module dt_engine_param
   import dt_pkg::*;
#(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int STI_W  = 16,
   parameter int DIST_W = 8,
   parameter int AW     = $clog2(IMG_W * IMG_H),
   parameter int SW     = $clog2(IMG_W * IMG_H / STI_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic              sti_rd,
   output logic [SW-1:0]     sti_addr,
   input  logic [STI_W-1:0]  sti_di,
   output logic              res_wr,
   output logic              res_rd,
   output logic [AW-1:0]     res_addr,
   output logic [DIST_W-1:0] res_do,
   input  logic [DIST_W-1:0] res_di
);

   localparam int            XB          = $clog2(IMG_W);
   localparam int            LSW         = $clog2(STI_W);
   localparam logic [AW-1:0] P_LAST      = AW'(IMG_W * IMG_H - 1);
   localparam logic [AW-1:0] P_BWD_FIRST = AW'(IMG_W * IMG_H - IMG_W - 2);
   localparam logic [AW-1:0] P_BWD_LAST  = AW'(IMG_W + 1);

   state_t            state, state_nx;
   logic [AW-1:0]     p, p_nx;
   logic [2:0]        k, k_nx;
   logic              mode_lat, mode_nx;
   logic              obj, obj_nx;

   logic [XB-1:0]     x;
   logic [AW-XB-1:0]  y;
   logic              border, object, bwd;
   int                ofs;
   logic [AW-1:0]     rd_addr;
   logic [2:0]        last_k;
   logic              nbr_clr, nbr_we;
   logic [2:0]        nbr_idx;
   logic [DIST_W-1:0] nbr_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         p        <= '0;
         k        <= '0;
         mode_lat <= DT_CHESS;
         obj      <= 1'b0;
      end else begin
         state    <= state_nx;
         p        <= p_nx;
         k        <= k_nx;
         mode_lat <= mode_nx;
         obj      <= obj_nx;
      end
   end

   // Pixel classification and neighbour addressing.
   always_comb begin
      x        = p[XB-1:0];
      y        = p[AW-1:XB];
      border   = (x == '0) || (x == '1) || (y == '0) || (y == '1);
      object   = sti_di[~p[LSW-1:0]] && !border;
      sti_addr = p[AW-1:LSW];
      bwd      = (state == BWD_RD);
      ofs      = nbr_ofs(bwd, mode_lat, k, IMG_W);
      rd_addr  = AW'(32'(p) + ofs);
      last_k   = nbr_last(bwd, mode_lat);
      nbr_idx  = (bwd && (k == last_k)) ? SELF_IDX : k;
   end

   always_comb begin
      state_nx = state;
      p_nx     = p;
      k_nx     = k;
      mode_nx  = mode_lat;
      obj_nx   = obj;
      busy     = 1'b0;
      done     = 1'b0;
      sti_rd   = 1'b0;
      res_rd   = 1'b0;
      res_wr   = 1'b0;
      res_addr = p;
      res_do   = '0;
      nbr_clr  = 1'b0;
      nbr_we   = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               state_nx = FWD_CHK;
               p_nx     = '0;
               k_nx     = '0;
               mode_nx  = mode;
               nbr_clr  = 1'b1;
            end
         end
         FWD_CHK: begin
            busy     = 1'b1;
            sti_rd   = 1'b1;
            obj_nx   = object;
            k_nx     = '0;
            state_nx = object ? FWD_RD : FWD_WR;
         end
         FWD_RD, BWD_RD: begin
            busy     = 1'b1;
            res_rd   = 1'b1;
            res_addr = rd_addr;
            nbr_we   = 1'b1;
            if (k == last_k) state_nx = (state == FWD_RD) ? FWD_WR : BWD_WR;
            else             k_nx     = k + 3'd1;
         end
         FWD_WR: begin
            busy   = 1'b1;
            res_wr = 1'b1;
            res_do = obj ? nbr_out : '0;
            if (p == P_LAST) begin
               state_nx = BWD_CHK;
               p_nx     = P_BWD_FIRST;
            end else begin
               state_nx = FWD_CHK;
               p_nx     = p + AW'(1);
            end
         end
         BWD_CHK: begin
            busy   = 1'b1;
            sti_rd = 1'b1;
            k_nx   = '0;
            if (object)                state_nx = BWD_RD;
            else if (p == P_BWD_LAST)  state_nx = DONE;
            else                       p_nx     = p - AW'(1);
         end
         BWD_WR: begin
            busy   = 1'b1;
            res_wr = 1'b1;
            res_do = nbr_out;
            if (p == P_BWD_LAST) begin
               state_nx = DONE;
            end else begin
               state_nx = BWD_CHK;
               p_nx     = p - AW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   dt_nbr_min #(
      .DIST_W (DIST_W)
   ) u_nbr (
      .clk   (clk),
      .reset (reset),
      .clr   (nbr_clr),
      .we    (nbr_we),
      .idx   (nbr_idx),
      .din   (res_di),
      .dout  (nbr_out)
   );

endmodule
`default_nettype wire

// File: tb/tb_dt_engine_param.sv
`default_nettype none
//==============================================================================
// tb_dt_engine_param - scoreboard bench, 16x16/DIST_W 8 and 32x32/DIST_W 3 engines. Rev 1.0
//==============================================================================
module tb_dt_engine_param;

   localparam int K_MEM = 0, K_WR = 1, K_RD = 2, K_OVL = 3, K_OUTS = 4, K_HS = 5;

   typedef struct {
      int    dut;
      int    kind;
      int    addr;
      int    exp;
      string name;
   } item_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // 16x16 engine (a) and 32x32 engine with 3-bit distances (b)
   logic        start_a, mode_a, busy_a, done_a, sti_rd_a, res_wr_a, res_rd_a, fill_a;
   logic [3:0]  sti_addr_a;
   logic [15:0] sti_di_a;
   logic [7:0]  res_addr_a, res_do_a, res_di_a;
   logic [15:0] sti_a [16];
   logic [7:0]  res_a [256];

   logic        start_b, mode_b, busy_b, done_b, sti_rd_b, res_wr_b, res_rd_b, fill_b;
   logic [5:0]  sti_addr_b;
   logic [15:0] sti_di_b;
   logic [9:0]  res_addr_b;
   logic [2:0]  res_do_b, res_di_b;
   logic [15:0] sti_b [64];
   logic [2:0]  res_b [1024];

   int wr_a, rd_a, ovl_a, wr_b, rd_b, ovl_b;

   dt_engine_param #(.IMG_W(16), .IMG_H(16), .STI_W(16), .DIST_W(8)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .busy(busy_a), .done(done_a),
      .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a), .res_wr(res_wr_a),
      .res_rd(res_rd_a), .res_addr(res_addr_a), .res_do(res_do_a), .res_di(res_di_a));

   dt_engine_param #(.IMG_W(32), .IMG_H(32), .STI_W(16), .DIST_W(3)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .busy(busy_b), .done(done_b),
      .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b), .res_wr(res_wr_b),
      .res_rd(res_rd_b), .res_addr(res_addr_b), .res_do(res_do_b), .res_di(res_di_b));

   assign sti_di_a = sti_a[sti_addr_a];
   assign res_di_a = res_a[res_addr_a];
   assign sti_di_b = sti_b[sti_addr_b];
   assign res_di_b = res_b[res_addr_b];

   always @(posedge clk) begin
      if (fill_a) for (int i = 0; i < 256; i++) res_a[i] <= 8'hA5;
      else if (res_wr_a) res_a[res_addr_a] <= res_do_a;
      if (fill_b) for (int i = 0; i < 1024; i++) res_b[i] <= 3'h5;
      else if (res_wr_b) res_b[res_addr_b] <= res_do_b;
   end

   always @(posedge clk) begin
      if (start_a && !busy_a) begin
         wr_a <= 0; rd_a <= 0; ovl_a <= 0;
      end else begin
         if (res_wr_a) wr_a <= wr_a + 1;
         if (res_rd_a) rd_a <= rd_a + 1;
         if (res_wr_a && res_rd_a) ovl_a <= ovl_a + 1;
      end
      if (start_b && !busy_b) begin
         wr_b <= 0; rd_b <= 0; ovl_b <= 0;
      end else begin
         if (res_wr_b) wr_b <= wr_b + 1;
         if (res_rd_b) rd_b <= rd_b + 1;
         if (res_wr_b && res_rd_b) ovl_b <= ovl_b + 1;
      end
   end

   item_t sb[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   event  chk_ev;

   int pts3_addr  [13] = '{153, 17, 119, 135, 68, 165, 60, 136, 118, 170, 204, 212, 80};
   int pts3_chess [13] = '{  1,  1,   1,   1,  4,   3,  3,   0,   2,   2,   3,   2,  0};
   int pts3_city  [13] = '{  2,  1,   2,   1,  4,   5,  3,   0,   3,   4,   3,   2,  0};
   int pts32_addr [12] = '{495, 33, 163, 74, 990, 351, 660, 518, 537, 0, 31, 66};
   int pts32_val  [12] = '{  7,  1,   3,  2,   1,   0,   7,   6,   6, 0,  0,  2};

   function automatic int actual_of(item_t it);
      int v;
      v = -1;
      case (it.kind)
         K_MEM:  v = (it.dut == 0) ? int'(res_a[it.addr]) : int'(res_b[it.addr]);
         K_WR:   v = (it.dut == 0) ? wr_a : wr_b;
         K_RD:   v = (it.dut == 0) ? rd_a : rd_b;
         K_OVL:  v = (it.dut == 0) ? ovl_a : ovl_b;
         K_OUTS: v = int'({busy_a, done_a, sti_rd_a, res_wr_a, res_rd_a,
                           |sti_addr_a, |res_addr_a, |res_do_a});
         K_HS:   v = int'({busy_a, done_a});
         default: v = -1;
      endcase
      return v;
   endfunction

   task automatic push(input int dut, input int kind, input int addr, input int exp,
                       input string name);
      item_t it;
      it.dut = dut; it.kind = kind; it.addr = addr; it.exp = exp; it.name = name;
      sb.push_back(it);
   endtask

   task automatic push_counts(input int dut, input int wr, input int rd);
      push(dut, K_WR, 0, wr, "res_write_count");
      push(dut, K_RD, 0, rd, "res_read_count");
      push(dut, K_OVL, 0, 0, "rd_wr_overlap_count");
   endtask

   task automatic push_pts3(input bit city);
      for (int i = 0; i < 13; i++)
         push(0, K_MEM, pts3_addr[i], city ? pts3_city[i] : pts3_chess[i],
              city ? "ring_city_res" : "ring_chess_res");
   endtask

   task automatic begin_run(input int dut, input logic m);
      if (dut == 0) fill_a = 1'b1; else fill_b = 1'b1;
      @(negedge clk);
      fill_a = 1'b0; fill_b = 1'b0;
      if (dut == 0) begin start_a = 1'b1; mode_a = m; end
      else          begin start_b = 1'b1; mode_b = m; end
      @(negedge clk);
      start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
   endtask

   task automatic wait_done(input int dut, input int budget);
      int n;
      n = 0;
      while (((dut == 0) ? done_a : done_b) == 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (((dut == 0) ? done_a : done_b) == 1'b0) begin
         n_chk++; n_fail++;
         $display("FAIL done_timeout: done=0 after %0d cycles, required 1", budget);
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : monitor
      item_t it;
      int    act;
      forever begin
         @(posedge done_a or posedge done_b or chk_ev);
         @(negedge clk);
         while (sb.size() > 0) begin
            it  = sb.pop_front();
            act = actual_of(it);
            n_chk++;
            if (act != it.exp) begin
               n_fail++;
               $display("FAIL %s (dut %0d addr %0d): got %0d, required %0d",
                        it.name, it.dut, it.addr, act, it.exp);
            end
         end
      end
   end

   initial begin : stim
      int n;
      start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
      fill_a  = 1'b0; fill_b = 1'b0;
      for (int i = 0; i < 16; i++) sti_a[i] = 16'h0000;
      for (int i = 0; i < 64; i++) sti_b[i] = 16'hFFFF;

      repeat (3) @(negedge clk);
      push(0, K_OUTS, 0, 0, "reset_outputs");
      -> chk_ev;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // All-background image
      for (int i = 0; i < 256; i++) push(0, K_MEM, i, 0, "zero_img_res");
      push_counts(0, 256, 0);
      begin_run(0, 1'b0);
      wait_done(0, 5000);

      // Single object pixel at (5,5)
      sti_a[5] = 16'h0400;
      for (int i = 0; i < 256; i++) push(0, K_MEM, i, (i == 85) ? 1 : 0, "single_px_res");
      push_counts(0, 257, 9);
      push(0, K_HS, 0, 1, "busy_done_at_done");
      begin_run(0, 1'b0);
      wait_done(0, 5000);

      // Interior block with a background hole at (8,8)
      for (int i = 0; i < 16; i++) sti_a[i] = (i == 0 || i == 15) ? 16'h0000 : 16'h7FFE;
      sti_a[8] = 16'h7F7E;
      push_pts3(1'b0);
      push_counts(0, 451, 1755);
      begin_run(0, 1'b0);
      wait_done(0, 5000);

      push_pts3(1'b1);
      push_counts(0, 451, 975);
      begin_run(0, 1'b1);
      wait_done(0, 5000);

      // Restart attempt mid forward pass must be ignored
      push_pts3(1'b0);
      push_counts(0, 451, 1755);
      begin_run(0, 1'b0);
      repeat (100) @(negedge clk);
      start_a = 1'b1; mode_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; mode_a = 1'b0;
      wait_done(0, 5000);

      // Reset in the backward pass, then a clean rerun
      begin_run(0, 1'b1);
      n = 0;
      while (wr_a <= 300 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (wr_a <= 300) begin
         n_chk++; n_fail++;
         $display("FAIL bwd_reach_timeout: writes=%0d, required >300", wr_a);
      end
      reset = 1'b0;
      push(0, K_OUTS, 0, 0, "abort_outputs");
      -> chk_ev;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      push_pts3(1'b1);
      push_counts(0, 451, 975);
      begin_run(0, 1'b1);
      wait_done(0, 5000);

      // 32x32, 3-bit distances, every STI bit set (border rule must hold)
      for (int i = 0; i < 12; i++) push(1, K_MEM, pts32_addr[i], pts32_val[i], "sat32_res");
      push_counts(1, 1924, 4500);
      begin_run(1, 1'b1);
      wait_done(1, 20000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
